// File: rtl/calipso_pkg.sv
// Shared types and default region boundaries for the Calipso ROM loader.
package calipso_pkg;

  typedef enum logic [1:0] {
    REG_CPU  = 2'd0,
    REG_SND  = 2'd1,
    REG_GFX  = 2'd2,
    REG_PROM = 2'd3
  } region_t;

  localparam logic [15:0] CPU_END_DEF  = 16'h6000;
  localparam logic [15:0] SND_END_DEF  = 16'h7000;
  localparam logic [15:0] GFX_END_DEF  = 16'h9000;
  localparam logic [15:0] PROM_END_DEF = 16'h9020;

  localparam int unsigned CNT_W = 17;

  // Loader states kept as plain constants so the encoding stays fixed.
  typedef logic [2:0] ld_state_t;
  localparam ld_state_t ST_IDLE  = 3'd0;
  localparam ld_state_t ST_LOAD  = 3'd1;
  localparam ld_state_t ST_DRAIN = 3'd2;
  localparam ld_state_t ST_DONE  = 3'd3;
  localparam ld_state_t ST_ERR   = 3'd4;

endpackage

// File: rtl/rom_region_decode.sv
// Maps a flat image byte address to a ROM region and region-relative offset.
module rom_region_decode
  import calipso_pkg::*;
#(
  parameter logic [15:0] CPU_END  = CPU_END_DEF,
  parameter logic [15:0] SND_END  = SND_END_DEF,
  parameter logic [15:0] GFX_END  = GFX_END_DEF,
  parameter logic [15:0] PROM_END = PROM_END_DEF
) (
  input  logic [24:0] i_addr,
  output region_t     o_region_c,
  output logic [15:0] o_offset_c,
  output logic        o_in_range_c
);

  logic [15:0] w_a;
  assign w_a = i_addr[15:0];

  // Region is chosen before subtracting, so offsets never wrap.
  always_comb begin
    o_region_c   = REG_CPU;
    o_offset_c   = w_a;
    o_in_range_c = (i_addr[24:16] == 9'd0);
    if (w_a < CPU_END) begin
      o_region_c = REG_CPU;
      o_offset_c = w_a;
    end else if (w_a < SND_END) begin
      o_region_c = REG_SND;
      o_offset_c = w_a - CPU_END;
    end else if (w_a < GFX_END) begin
      o_region_c = REG_GFX;
      o_offset_c = w_a - SND_END;
    end else if (w_a < PROM_END) begin
      o_region_c = REG_PROM;
      o_offset_c = w_a - GFX_END;
    end else begin
      o_in_range_c = 1'b0;
    end
  end

endmodule

// File: rtl/calipso_rom_loader.sv
// Decodes the hps_io ROM download into per-region writes through a one-entry
// skid buffer, and holds the core in reset until a correctly sized image lands.
module calipso_rom_loader
  import calipso_pkg::*;
#(
  parameter logic [15:0] CPU_END  = CPU_END_DEF,
  parameter logic [15:0] SND_END  = SND_END_DEF,
  parameter logic [15:0] GFX_END  = GFX_END_DEF,
  parameter logic [15:0] PROM_END = PROM_END_DEF
) (
  input  logic        clk_sys,
  input  logic        RESET_N,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  output logic        ioctl_wait,
  output logic [15:0] dn_addr,
  output logic [7:0]  dn_data,
  output logic [1:0]  dn_region,
  output logic        dn_wr,
  input  logic        dn_ack,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err,
  output logic [7:0]  checksum
);

  ld_state_t        r_state;
  ld_state_t        w_state_nxt;
  logic             r_dl_q;
  logic             r_restart_pend;
  logic             r_dn_wr;
  logic [15:0]      r_dn_addr;
  logic [7:0]       r_dn_data;
  region_t          r_dn_region;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_checksum;
  logic             r_load_err;
  logic             r_load_done;
  logic             r_core_reset;

  region_t          w_region;
  logic [15:0]      w_offset;
  logic             w_in_range;
  logic             w_start;
  logic             w_fall;
  logic             w_empty;
  logic             w_in_load;
  logic             w_accept;
  logic             w_bad_wr;
  logic             w_clear;
  logic             w_size_err;

  rom_region_decode #(
    .CPU_END (CPU_END),
    .SND_END (SND_END),
    .GFX_END (GFX_END),
    .PROM_END(PROM_END)
  ) u_decode (
    .i_addr      (ioctl_addr),
    .o_region_c  (w_region),
    .o_offset_c  (w_offset),
    .o_in_range_c(w_in_range)
  );

  assign w_start   = ioctl_download & ~r_dl_q & (ioctl_index == 8'd0);
  assign w_fall    = ~ioctl_download & r_dl_q;
  // The buffer frees in the same cycle its write is acknowledged.
  assign w_empty   = ~r_dn_wr | dn_ack;
  assign w_in_load = (r_state == ST_LOAD);
  assign w_accept  = w_in_load & ioctl_wr & w_empty & w_in_range;
  assign w_bad_wr  = w_in_load & ioctl_wr & (~w_empty | ~w_in_range);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE, ST_ERR: if (w_start) w_state_nxt = ST_LOAD;
      ST_LOAD:                  if (w_fall) w_state_nxt = ST_DRAIN;
      ST_DRAIN: begin
        if (w_empty) begin
          if (w_start || r_restart_pend)         w_state_nxt = ST_LOAD;
          else if (r_count == CNT_W'(PROM_END))  w_state_nxt = ST_DONE;
          else                                   w_state_nxt = ST_ERR;
        end
      end
      default:                  w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_clear    = (w_state_nxt == ST_LOAD) && (r_state != ST_LOAD);
  assign w_size_err = (r_state == ST_DRAIN) && (w_state_nxt == ST_ERR);

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_sys or negedge RESET_N) begin
    if (!RESET_N) begin
      r_dl_q         <= 1'b0;
      r_restart_pend <= 1'b0;
      r_dn_wr        <= 1'b0;
      r_dn_addr      <= 16'd0;
      r_dn_data      <= 8'd0;
      r_dn_region    <= REG_CPU;
      r_count        <= '0;
      r_checksum     <= 8'd0;
      r_load_err     <= 1'b0;
      r_load_done    <= 1'b0;
      r_core_reset   <= 1'b1;
    end else begin
      r_dl_q <= ioctl_download;

      // A new download seen while the last write is pending waits for the ack.
      if (w_clear)
        r_restart_pend <= 1'b0;
      else if ((r_state == ST_DRAIN) && w_start && !w_empty)
        r_restart_pend <= 1'b1;

      if (w_accept) begin
        r_dn_wr     <= 1'b1;
        r_dn_addr   <= w_offset;
        r_dn_data   <= ioctl_dout;
        r_dn_region <= w_region;
      end else if (dn_ack) begin
        r_dn_wr <= 1'b0;
      end

      if (w_clear) begin
        r_count    <= '0;
        r_checksum <= 8'd0;
      end else if (w_accept) begin
        if (r_count != {CNT_W{1'b1}}) r_count <= r_count + CNT_W'(1);
        r_checksum <= r_checksum + ioctl_dout;
      end

      if (w_clear)                    r_load_err <= 1'b0;
      else if (w_bad_wr || w_size_err) r_load_err <= 1'b1;

      r_load_done  <= (w_state_nxt == ST_DONE);
      r_core_reset <= (w_state_nxt != ST_DONE);
    end
  end

  assign ioctl_wait = r_dn_wr;
  assign dn_wr      = r_dn_wr;
  assign dn_addr    = r_dn_addr;
  assign dn_data    = r_dn_data;
  assign dn_region  = r_dn_region;
  assign checksum   = r_checksum;
  assign load_err   = r_load_err;
  assign load_done  = r_load_done;
  assign core_reset = r_core_reset;

endmodule

// File: tb/tb_calipso_rom_loader.sv
// Directed bench for calipso_rom_loader: image-level model of expected writes,
// per-cycle write/handshake checker, and literal end-of-test expectations.
module tb_calipso_rom_loader;

  localparam int IMG = 32'h9020;

  logic        clk_sys = 1'b0;
  logic        RESET_N = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = 25'd0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        dn_ack = 1'b1;
  logic        ioctl_wait;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic [1:0]  dn_region;
  logic        dn_wr;
  logic        core_reset;
  logic        load_done;
  logic        load_err;
  logic [7:0]  checksum;

  calipso_rom_loader dut (
    .clk_sys       (clk_sys),
    .RESET_N       (RESET_N),
    .ioctl_download(ioctl_download),
    .ioctl_index   (ioctl_index),
    .ioctl_wr      (ioctl_wr),
    .ioctl_addr    (ioctl_addr),
    .ioctl_dout    (ioctl_dout),
    .ioctl_wait    (ioctl_wait),
    .dn_addr       (dn_addr),
    .dn_data       (dn_data),
    .dn_region     (dn_region),
    .dn_wr         (dn_wr),
    .dn_ack        (dn_ack),
    .core_reset    (core_reset),
    .load_done     (load_done),
    .load_err      (load_err),
    .checksum      (checksum)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]  rg;
    logic [15:0] off;
    logic [7:0]  d;
  } wr_t;

  int n_pass = 0;
  int n_tot  = 0;

  // Image-level model of the loader.
  wr_t        exp_q[$];
  bit         m_loading = 1'b0;
  bit         m_done = 1'b0;
  bit         m_err = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_sum = 8'd0;

  // Observations from the write port.
  int          obs_cnt = 0;
  int          first_idx[4];
  logic [15:0] first_off[4];
  logic [1:0]  last_reg = 2'd0;
  logic [15:0] last_off = 16'd0;
  int          wait_cycles = 0;

  bit stall_mode = 1'b0;
  int stall_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail_now(input string name, input int act, input int exp);
    n_tot++;
    $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
    end
  endtask

  task automatic obs_clear();
    obs_cnt = 0;
    for (int r = 0; r < 4; r++) begin
      first_idx[r] = -1;
      first_off[r] = 16'hFFFF;
    end
  endtask

  function automatic void model_push(input logic [24:0] a, input logic [7:0] d);
    int  ai;
    wr_t e;
    ai = int'(a);
    if (!m_loading) return;
    if (ai >= IMG) begin
      m_err = 1'b1;
      return;
    end
    e.d = d;
    if (ai < 32'h6000)      begin e.rg = 2'd0; e.off = 16'(ai); end
    else if (ai < 32'h7000) begin e.rg = 2'd1; e.off = 16'(ai - 32'h6000); end
    else if (ai < 32'h9000) begin e.rg = 2'd2; e.off = 16'(ai - 32'h7000); end
    else                    begin e.rg = 2'd3; e.off = 16'(ai - 32'h9000); end
    exp_q.push_back(e);
    m_cnt++;
    m_sum = m_sum + d;
  endfunction

  task automatic send_byte(input logic [24:0] a, input logic [7:0] d);
    int guard;
    guard = 0;
    while (stall_mode && ioctl_wait === 1'b1) begin
      ioctl_wr = 1'b0;
      tick(1);
      guard++;
      if (guard > 50) begin
        fail_now("wait_timeout", guard, 50);
        break;
      end
    end
    ioctl_wr   = 1'b1;
    ioctl_addr = a;
    ioctl_dout = d;
    model_push(a, d);
    tick(1);
    ioctl_wr = 1'b0;
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index    = idx;
    ioctl_download = 1'b1;
    if (idx == 8'd0) begin
      m_loading = 1'b1;
      m_cnt     = 0;
      m_sum     = 8'd0;
      m_err     = 1'b0;
      m_done    = 1'b0;
    end
    tick(1);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    if (m_loading) begin
      m_loading = 1'b0;
      m_done    = (m_cnt == IMG);
      if (!m_done) m_err = 1'b1;
    end
  endtask

  task automatic drain_wait();
    int g;
    g = 0;
    while ((dn_wr !== 1'b0 || exp_q.size() != 0) && g < 300) begin
      tick(1);
      g++;
    end
    if (g >= 300) fail_now("drain_timeout", g, 300);
    tick(3);
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_load_done"},  32'(load_done),  32'(m_done));
    chk({tag, "_load_err"},   32'(load_err),   32'(m_err));
    chk({tag, "_core_reset"}, 32'(core_reset), 32'(!m_done));
    chk({tag, "_checksum"},   32'(checksum),   32'(m_sum));
    chk({tag, "_leftover"},   32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ioctl_wait"}, 32'(ioctl_wait), 32'd0);
    chk({tag, "_dn_wr"},      32'(dn_wr),      32'd0);
    chk({tag, "_dn_addr"},    32'(dn_addr),    32'd0);
    chk({tag, "_dn_data"},    32'(dn_data),    32'd0);
    chk({tag, "_dn_region"},  32'(dn_region),  32'd0);
    chk({tag, "_core_reset"}, 32'(core_reset), 32'd1);
    chk({tag, "_load_done"},  32'(load_done),  32'd0);
    chk({tag, "_load_err"},   32'(load_err),   32'd0);
    chk({tag, "_checksum"},   32'(checksum),   32'd0);
  endtask

  // Acknowledge driver: optionally holds dn_ack low for 3 cycles per write.
  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (!stall_mode) begin
        dn_ack = 1'b1;
        stall_cnt = 0;
      end else if (dn_wr === 1'b1 && stall_cnt < 3) begin
        dn_ack = 1'b0;
        stall_cnt++;
      end else begin
        dn_ack = 1'b1;
        stall_cnt = 0;
      end
    end
  end

  // Per-cycle checker of the write port against the model queue.
  logic        pv_stall = 1'b0;
  logic [15:0] pv_addr = 16'd0;
  logic [7:0]  pv_data = 8'd0;
  logic [1:0]  pv_reg = 2'd0;
  initial begin
    forever begin
      @(negedge clk_sys);
      if (RESET_N === 1'b1) begin
        if (ioctl_wait === 1'b1) wait_cycles++;
        if (dn_wr === 1'b1 && dn_ack === 1'b0) chk("wait_while_stalled", 32'(ioctl_wait), 32'd1);
        if (dn_wr === 1'b0) chk("wait_while_empty", 32'(ioctl_wait), 32'd0);
        if (pv_stall) begin
          chk("stall_hold_addr",   32'(dn_addr),   32'(pv_addr));
          chk("stall_hold_data",   32'(dn_data),   32'(pv_data));
          chk("stall_hold_region", 32'(dn_region), 32'(pv_reg));
        end
        if (dn_wr === 1'b1 && dn_ack === 1'b1) begin
          if (exp_q.size() == 0) begin
            fail_now("unexpected_write", int'(dn_addr), -1);
          end else begin
            wr_t e;
            e = exp_q.pop_front();
            chk("wr_region", 32'(dn_region), 32'(e.rg));
            chk("wr_offset", 32'(dn_addr),   32'(e.off));
            chk("wr_data",   32'(dn_data),   32'(e.d));
          end
          if (first_idx[dn_region] < 0) begin
            first_idx[dn_region] = obs_cnt;
            first_off[dn_region] = dn_addr;
          end
          last_reg = dn_region;
          last_off = dn_addr;
          obs_cnt++;
        end
        pv_stall = (dn_wr === 1'b1) && (dn_ack === 1'b0);
        pv_addr  = dn_addr;
        pv_data  = dn_data;
        pv_reg   = dn_region;
      end else begin
        pv_stall = 1'b0;
      end
    end
  end

  initial begin
    obs_clear();
    #3 RESET_N = 1'b0;
    tick(2);
    check_reset_vals("por");
    RESET_N = 1'b1;
    tick(2);

    // Partial load aborted by reset at byte 0x3000.
    start_dl(8'd0);
    for (int a = 0; a < 32'h3000; a++) send_byte(25'(a), 8'(a));
    RESET_N        = 1'b0;
    ioctl_download = 1'b0;
    exp_q.delete();
    m_loading = 1'b0;
    m_done    = 1'b0;
    m_err     = 1'b0;
    m_cnt     = 0;
    m_sum     = 8'd0;
    #1;
    check_reset_vals("midload_reset");
    tick(2);
    RESET_N = 1'b1;
    tick(2);

    // Full image, data = addr[7:0], ack tied high.
    obs_clear();
    start_dl(8'd0);
    for (int a = 0; a < IMG; a++) send_byte(25'(a), 8'(a));
    end_dl();
    tick(1);
    chk("full_core_reset_in_drain", 32'(core_reset), 32'd1);
    tick(1);
    chk("full_core_reset_after_drain", 32'(core_reset), 32'd0);
    chk("full_load_done_lit", 32'(load_done), 32'd1);
    tick(2);
    check_status("full");
    chk("full_write_count", 32'(obs_cnt), 32'h9020);
    chk("full_snd_first_idx", 32'(first_idx[1]), 32'h6000);
    chk("full_snd_first_off", 32'(first_off[1]), 32'd0);
    chk("full_gfx_first_idx", 32'(first_idx[2]), 32'h7000);
    chk("full_gfx_first_off", 32'(first_off[2]), 32'd0);
    chk("full_prom_first_idx", 32'(first_idx[3]), 32'h9000);
    chk("full_prom_first_off", 32'(first_off[3]), 32'd0);
    chk("full_last_region", 32'(last_reg), 32'd3);
    chk("full_last_offset", 32'(last_off), 32'h1F);
    // Sum of addr[7:0] over 0..0x901F: 144 whole pages cancel, 0..31 gives 0x1F0.
    chk("full_checksum_lit", 32'(checksum), 32'hF0);
    chk("full_load_err_lit", 32'(load_err), 32'd0);

    // Non-ROM index: ignored entirely.
    obs_clear();
    start_dl(8'd1);
    for (int a = 0; a < 4; a++) send_byte(25'(a), 8'h5A);
    end_dl();
    drain_wait();
    chk("idx1_no_writes", 32'(obs_cnt), 32'd0);
    chk("idx1_load_done_lit", 32'(load_done), 32'd1);
    check_status("idx1");

    // Stalled acks: 3 low cycles per write, short image ends in error.
    obs_clear();
    stall_mode = 1'b1;
    wait_cycles = 0;
    start_dl(8'd0);
    for (int i = 0; i < 8; i++) send_byte(25'(32'h100 + i), 8'(32'hA5 + i));
    end_dl();
    drain_wait();
    stall_mode = 1'b0;
    tick(1);
    chk("stall_write_count", 32'(obs_cnt), 32'd8);
    chk("stall_wait_cycles", 32'(wait_cycles), 32'd32);
    chk("stall_checksum_lit", 32'(checksum), 32'h44);
    check_status("stall");

    // Out-of-range addresses only.
    obs_clear();
    start_dl(8'd0);
    send_byte(25'h0009020, 8'h11);
    send_byte(25'h0010000, 8'h22);
    end_dl();
    drain_wait();
    chk("oor_no_writes", 32'(obs_cnt), 32'd0);
    chk("oor_load_err_lit", 32'(load_err), 32'd1);
    chk("oor_checksum_lit", 32'(checksum), 32'd0);
    check_status("oor");

    // Short image of 0x8000 bytes.
    obs_clear();
    start_dl(8'd0);
    for (int a = 0; a < 32'h8000; a++) send_byte(25'(a), 8'(a));
    end_dl();
    drain_wait();
    chk("short_write_count", 32'(obs_cnt), 32'h8000);
    chk("short_load_err_lit", 32'(load_err), 32'd1);
    chk("short_load_done_lit", 32'(load_done), 32'd0);
    chk("short_core_reset_lit", 32'(core_reset), 32'd1);
    check_status("short");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
